// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM state type and default sizing for the fifo push arbiter
package fifo_arb_pkg;
  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
  typedef enum logic {IDLE, OWN} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot round-robin select of the first request after last_owner
module rr_pick #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_owner,
  output logic [N-1:0]  sel
);
  // scan from farthest to nearest so the nearest requester after last_owner wins
  always_comb begin
    sel = '0;
    for (int k = N; k >= 1; k--)
      if (req[IW'((int'(last_owner) + k) % N)]) sel = N'(1) << ((int'(last_owner) + k) % N);
  end
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin burst arbiter sharing one fifo push port
module fifo_push_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     full,
  output logic                     push,
  output logic [WIDTH-1:0]         datain,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  state_t state, state_nx;
  logic [NUM_REQ-1:0] sel;
  logic [IW-1:0] owner, last_owner, sel_idx;
  logic [BW-1:0] burst_cnt;
  logic release_own;
  logic [WIDTH-1:0] slot [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign slot[g] = req_data[g*WIDTH +: WIDTH];
  end
  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req       (req),
    .last_owner(last_owner),
    .sel       (sel)
  );
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel[IW'(i)]) sel_idx = IW'(i);
  end
  assign push = (state == OWN) && req[owner] && !full;
  assign datain = slot[owner];
  assign ack = push ? gnt : '0;
  // a requester dropping req ends the burst even while the fifo is full
  assign release_own = !req[owner] || (push && burst_cnt == BW'(MAX_BURST - 1));
  always_comb begin
    state_nx = state == IDLE ? (|req ? OWN : IDLE) : (release_own ? IDLE : OWN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      burst_cnt <= '0;
      last_owner <= IW'(NUM_REQ - 1);
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        gnt <= sel;
        owner <= sel_idx;
        burst_cnt <= '0;
      end else if (release_own) begin
        gnt <= '0;
        last_owner <= owner;
      end else if (push) begin
        burst_cnt <= burst_cnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scoreboard bench for the fifo push arbiter
module tb_fifo_push_arbiter;
  typedef struct {
    int         idx;
    logic [7:0] d;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        full = 1'b0;
  logic        push;
  logic [7:0]  datain;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  src [4][$];
  exp_t        exp_q [$];
  logic [3:0]  gseq [$];
  int          pcnt [$];
  int          zrun [$];
  logic [3:0]  prev_gnt = '0;
  int          zeros = 0;
  int          npush = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          tot_cnt = 0;
  logic        full_ovr = 1'b0;
  logic        fifo_mode = 1'b0;
  int          fcnt = 0;

  fifo_push_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .full(full),
    .push(push), .datain(datain), .gnt(gnt), .ack(ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tot_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      req[i] = src[i].size() > 0;
      req_data[i*8 +: 8] = src[i].size() > 0 ? src[i][0] : 8'h00;
    end
    full = fifo_mode ? (fcnt >= 4) : full_ovr;
  endtask

  task automatic add(input int i, input logic [7:0] d);
    exp_t e;
    e.idx = i;
    e.d = d;
    src[i].push_back(d);
    exp_q.push_back(e);
  endtask

  task automatic clear_log();
    gseq.delete();
    pcnt.delete();
    zrun.delete();
    zeros = 0;
    prev_gnt = '0;
    npush = 0;
  endtask

  // sample at negedge, let the requesters consume acked words just after the edge
  task automatic tick();
    logic [3:0] a;
    exp_t e;
    @(negedge clk);
    a = ack;
    if (gnt == 4'b0) zeros++;
    else begin
      if (gnt != prev_gnt) begin
        gseq.push_back(gnt);
        pcnt.push_back(0);
        zrun.push_back(zeros);
      end
      zeros = 0;
    end
    prev_gnt = gnt;
    if (full) chk("push_while_full", {31'b0, push}, 0);
    if (rst) chk("push_in_rst", {31'b0, push}, 0);
    if (push) begin
      npush++;
      if (pcnt.size() > 0) pcnt[pcnt.size()-1]++;
      if (exp_q.size() == 0) chk("unexpected_push", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("datain", {24'b0, datain}, {24'b0, e.d});
        chk("ack", {28'b0, ack}, 32'(1 << e.idx));
      end
    end else chk("ack_idle", {28'b0, ack}, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (a[i]) begin
        if (src[i].size() > 0) src[i].delete(0);
        if (fifo_mode) fcnt++;
      end
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int b;
    b = budget;
    while (exp_q.size() > 0 && b > 0) begin
      tick();
      b--;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) src[i].delete();
    exp_q.delete();
    full_ovr = 1'b0;
    drive();
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  initial begin
    int b;
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
    // reset state
    do_reset();
    chk("rst_gnt", {28'b0, gnt}, 0);
    chk("rst_push", {31'b0, push}, 0);
    chk("rst_ack", {28'b0, ack}, 0);
    // single requester burst of 4, bubble, regrant
    for (int k = 0; k < 5; k++) add(0, 8'(8'h10 + k));
    drive();
    tick();
    chk("s1_gnt_first", {28'b0, gnt}, 4'b0001);
    drain("s1_drain", 30);
    tick();
    tick();
    chk("s1_ngrants", gseq.size(), 2);
    chk("s1_g1", {28'b0, gseq[1]}, 4'b0001);
    chk("s1_burst0", pcnt[0], 4);
    chk("s1_burst1", pcnt[1], 1);
    chk("s1_bubble", zrun[1], 1);
    // all requesting: rotate 0,1,2,3,0 with 4-push bursts
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) add(i, 8'(i*16 + k));
    for (int k = 4; k < 8; k++) add(0, 8'(k));
    drive();
    drain("s2_drain", 80);
    tick();
    tick();
    chk("s2_ngrants", gseq.size(), 5);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("s2_order%0d", j), {28'b0, gseq[j]}, {28'b0, order[j]});
      chk($sformatf("s2_burst%0d", j), pcnt[j], 4);
      if (j > 0) chk($sformatf("s2_bubble%0d", j), zrun[j], 1);
    end
    // fifo full mid-burst holds grant and burst count
    do_reset();
    for (int k = 0; k < 5; k++) add(2, 8'(8'h40 + k));
    drive();
    b = 20;
    while (npush < 2 && b > 0) begin
      tick();
      b--;
    end
    chk("s3_two_pushes", npush, 2);
    full_ovr = 1'b1;
    drive();
    repeat (5) begin
      tick();
      chk("s3_gnt_hold", {28'b0, gnt}, 4'b0100);
      chk("s3_push_full", {31'b0, push}, 0);
    end
    full_ovr = 1'b0;
    drive();
    drain("s3_drain", 20);
    tick();
    tick();
    chk("s3_ngrants", gseq.size(), 2);
    chk("s3_burst0", pcnt[0], 4);
    chk("s3_burst1", pcnt[1], 1);
    chk("s3_bubble", zrun[1], 1);
    // owner drops req early, next requester gets a fresh burst
    do_reset();
    add(1, 8'h31);
    for (int k = 0; k < 4; k++) add(3, 8'(8'h70 + k));
    drive();
    drain("s4_drain", 30);
    tick();
    tick();
    chk("s4_ngrants", gseq.size(), 2);
    chk("s4_g0", {28'b0, gseq[0]}, 4'b0010);
    chk("s4_g1", {28'b0, gseq[1]}, 4'b1000);
    chk("s4_burst0", pcnt[0], 1);
    chk("s4_burst1", pcnt[1], 4);
    chk("s4_bubble", zrun[1], 1);
    // reset mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) add(3, 8'(8'h80 + k));
    drive();
    b = 20;
    while (npush < 2 && b > 0) begin
      tick();
      b--;
    end
    chk("s5_two_pushes", npush, 2);
    rst = 1'b1;
    #1;
    chk("s5_rst_gnt", {28'b0, gnt}, 0);
    chk("s5_rst_push", {31'b0, push}, 0);
    chk("s5_rst_ack", {28'b0, ack}, 0);
    for (int i = 0; i < 4; i++) src[i].delete();
    exp_q.delete();
    drive();
    tick();
    rst = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) add(i, 8'(8'h50 + i));
    drive();
    drain("s5_drain", 40);
    tick();
    tick();
    chk("s5_ngrants", gseq.size(), 4);
    chk("s5_first", {28'b0, gseq[0]}, 4'b0001);
    // depth-4 fifo with no pops
    do_reset();
    fifo_mode = 1'b1;
    fcnt = 0;
    for (int k = 0; k < 4; k++) add(0, 8'(8'h60 + k));
    src[0].push_back(8'h64);
    src[0].push_back(8'h65);
    drive();
    repeat (16) tick();
    chk("s6_pushes", npush, 4);
    chk("s6_fcnt", fcnt, 4);
    chk("s6_left", exp_q.size(), 0);
    chk("s6_gnt_held", {28'b0, gnt}, 4'b0001);
    fifo_mode = 1'b0;
    do_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
